// File: rtl/uart_rx_ctrl_if.sv
// Bundles the uart_rx_ctrl system-side, receiver-side and status signals.
// master = the controller itself, slave = the receiver/system environment.
interface uart_rx_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          enable;
    logic          cfg_wr;
    logic [11:0]   cfg_baud_divisor;
    logic          cfg_parity_sel;
    logic          cfg_stop_sel;
    logic [15:0]   cfg_timeout;
    logic          rx;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_parity_ok;
    logic          rx_en;
    logic [11:0]   baud_divisor;
    logic          parity_sel;
    logic          stop_sel;
    logic [7:0]    m_data;
    logic          m_perr;
    logic          m_valid;
    logic          m_ready;
    logic [CW-1:0] fifo_count;
    logic          cfg_pending;
    logic          overrun;
    logic [7:0]    perr_count;
    logic          timeout_irq;
    logic          err_clr;

    modport master (
        input  enable, cfg_wr, cfg_baud_divisor, cfg_parity_sel, cfg_stop_sel, cfg_timeout,
        input  rx, rx_data, rx_valid, rx_parity_ok, m_ready, err_clr,
        output rx_en, baud_divisor, parity_sel, stop_sel, m_data, m_perr, m_valid,
        output fifo_count, cfg_pending, overrun, perr_count, timeout_irq
    );

    modport slave (
        output enable, cfg_wr, cfg_baud_divisor, cfg_parity_sel, cfg_stop_sel, cfg_timeout,
        output rx, rx_data, rx_valid, rx_parity_ok, m_ready, err_clr,
        input  rx_en, baud_divisor, parity_sel, stop_sel, m_data, m_perr, m_valid,
        input  fifo_count, cfg_pending, overrun, perr_count, timeout_irq
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: frame-boundary config apply, byte FIFO with parity flag, error/idle tracking.
// Head visible one cycle after push (no fall-through); bytes dropped with sticky overrun when full and not popped.
module uart_rx_ctrl #(
    parameter int          DEPTH        = 8,
    parameter logic [11:0] RESET_BAUD   = 12'd10,
    parameter int          GUARD_CYCLES = 65535
) (
    input  logic           clk,
    input  logic           reset,
    uart_rx_ctrl_if.master bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GUARD_CYCLES + 1);

    typedef enum logic [1:0] {S_OFF, S_RUN, S_WAIT, S_APPLY} state_e;

    state_e        state_q;
    logic          rx_en_q;
    logic [11:0]   baud_q, sh_baud_q;
    logic          parity_q, sh_parity_q;
    logic          stop_q, sh_stop_q;
    logic          cfg_pending_q;
    logic          frame_active_q;
    logic [GW-1:0] guard_q;
    logic          rx_s1_q, rx_s2_q, rx_s3_q;

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overrun_q;
    logic [7:0]    perr_cnt_q;
    logic [15:0]   timer_q;
    logic          irq_q;

    logic rx_fall, pop, push_req, full, push_ok, drop, perr_evt, timer_run;

    assign rx_fall   = rx_s3_q & ~rx_s2_q;
    assign pop       = (count_q != '0) && bus.m_ready;
    assign push_req  = bus.rx_valid && (state_q != S_OFF);
    assign full      = (count_q == CW'(DEPTH));
    assign push_ok   = push_req && (!full || pop);
    assign drop      = push_req && full && !pop;
    assign perr_evt  = bus.rx_valid && !bus.rx_parity_ok;
    assign timer_run = (bus.cfg_timeout != 16'd0) && (count_q != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= bus.rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_OFF;
            rx_en_q        <= 1'b0;
            baud_q         <= RESET_BAUD;
            parity_q       <= 1'b0;
            stop_q         <= 1'b0;
            sh_baud_q      <= RESET_BAUD;
            sh_parity_q    <= 1'b0;
            sh_stop_q      <= 1'b0;
            cfg_pending_q  <= 1'b0;
            frame_active_q <= 1'b0;
            guard_q        <= '0;
        end else begin
            if (bus.cfg_wr) begin
                sh_baud_q     <= bus.cfg_baud_divisor;
                sh_parity_q   <= bus.cfg_parity_sel;
                sh_stop_q     <= bus.cfg_stop_sel;
                cfg_pending_q <= 1'b1;
            end
            if (rx_fall && rx_en_q) begin
                frame_active_q <= 1'b1;
            end else if (bus.rx_valid) begin
                frame_active_q <= 1'b0;
            end
            // Transitions into APPLY/OFF below override the frame tracking above.
            case (state_q)
                S_OFF: begin
                    frame_active_q <= 1'b0;
                    if (cfg_pending_q) begin
                        state_q <= S_APPLY;
                    end else if (bus.enable) begin
                        state_q <= S_RUN;
                        rx_en_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!bus.enable || cfg_pending_q) begin
                        if (!frame_active_q) begin
                            state_q        <= S_APPLY;
                            rx_en_q        <= 1'b0;
                            frame_active_q <= 1'b0;
                        end else begin
                            state_q <= S_WAIT;
                            guard_q <= '0;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.rx_valid || guard_q == GW'(GUARD_CYCLES - 1)) begin
                        state_q        <= S_APPLY;
                        rx_en_q        <= 1'b0;
                        frame_active_q <= 1'b0;
                    end else begin
                        guard_q <= guard_q + 1'b1;
                    end
                end
                S_APPLY: begin
                    if (cfg_pending_q) begin
                        baud_q   <= sh_baud_q;
                        parity_q <= sh_parity_q;
                        stop_q   <= sh_stop_q;
                        if (!bus.cfg_wr) cfg_pending_q <= 1'b0;
                    end
                    frame_active_q <= 1'b0;
                    if (bus.enable) begin
                        state_q <= S_RUN;
                        rx_en_q <= 1'b1;
                    end else begin
                        state_q <= S_OFF;
                        rx_en_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    rx_en_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overrun_q  <= 1'b0;
            perr_cnt_q <= 8'd0;
            timer_q    <= 16'd0;
            irq_q      <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {~bus.rx_parity_ok, bus.rx_data};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (drop)             overrun_q <= 1'b1;
            else if (bus.err_clr) overrun_q <= 1'b0;

            if (perr_evt) begin
                if (bus.err_clr)              perr_cnt_q <= 8'd1;
                else if (perr_cnt_q != 8'hFF) perr_cnt_q <= perr_cnt_q + 8'd1;
            end else if (bus.err_clr) begin
                perr_cnt_q <= 8'd0;
            end

            // Saturate rather than wrap so a long-idle queue cannot re-hit the threshold.
            if (push_ok || pop || !timer_run) timer_q <= 16'd0;
            else if (timer_q != 16'hFFFF)     timer_q <= timer_q + 16'd1;

            if (pop)                                           irq_q <= 1'b0;
            else if (timer_run && timer_q == bus.cfg_timeout)  irq_q <= 1'b1;
            else if (bus.err_clr)                              irq_q <= 1'b0;
        end
    end

    assign bus.rx_en        = rx_en_q;
    assign bus.baud_divisor = baud_q;
    assign bus.parity_sel   = parity_q;
    assign bus.stop_sel     = stop_q;
    assign bus.cfg_pending  = cfg_pending_q;
    assign bus.m_valid      = (count_q != '0);
    assign bus.m_data       = mem_q[rd_ptr_q][7:0];
    assign bus.m_perr       = mem_q[rd_ptr_q][8];
    assign bus.fifo_count   = count_q;
    assign bus.overrun      = overrun_q;
    assign bus.perr_count   = perr_cnt_q;
    assign bus.timeout_irq  = irq_q;
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control and buffering block that sits between the UART receiver datapath (uart_top_rx) and the system side. It owns the receiver's rx_en and frame-configuration inputs (baud_divisor, parity_sel, stop_sel). It applies configuration changes only on frame boundaries and buffers received bytes with per-byte parity status in a FIFO behind a ready/valid interface. It also tracks overrun, parity-error and idle-timeout conditions.

Parameters:
DEPTH, 8, FIFO entries; power of 2, at least 2
RESET_BAUD, 12'd10, baud_divisor value after reset
GUARD_CYCLES, 65535, maximum cycles WAIT may stall on an unfinished frame

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  software receive enable
cfg_wr  in  1  one-cycle strobe; latches cfg_* into the shadow registers
cfg_baud_divisor  in  12  new baud divisor
cfg_parity_sel  in  1  new parity select (0 = even, 1 = odd)
cfg_stop_sel  in  1  new stop select (0 = 1 stop bit, 1 = 2 stop bits)
cfg_timeout  in  16  idle-timeout threshold in clk cycles; 0 disables the timeout
rx  in  1  serial line (same net as the receiver input)
rx_data  in  8  receiver data_out
rx_valid  in  1  receiver valid_out (one-cycle pulse)
rx_parity_ok  in  1  receiver parity_ok, qualified by rx_valid
rx_en  out  1  receiver enable
baud_divisor  out  12  active divisor to receiver
parity_sel  out  1  active parity select to receiver
stop_sel  out  1  active stop select to receiver
m_data  out  8  FIFO head byte
m_perr  out  1  parity error flag for the head byte
m_valid  out  1  FIFO head valid
m_ready  in  1  consumer ready
fifo_count  out  $clog2(DEPTH)+1  current occupancy
cfg_pending  out  1  shadow configuration not yet applied
overrun  out  1  sticky; set when a byte is dropped
perr_count  out  8  saturating parity-error counter
timeout_irq  out  1  sticky idle-timeout flag
err_clr  in  1  clears overrun, perr_count and timeout_irq

Behaviour:
- Reset values: rx_en=0, baud_divisor=RESET_BAUD, parity_sel=0, stop_sel=0, m_valid=0, m_data=0, m_perr=0, fifo_count=0, cfg_pending=0, overrun=0, perr_count=0, timeout_irq=0. FSM enters OFF; FIFO is emptied. Reset asserted mid-operation discards all state immediately.
- rx is double-flop synchronised. frame_active is set on a synchronised falling edge while rx_en=1. It clears on rx_valid, on entering APPLY or OFF, or on guard expiry.
- cfg_wr loads the shadow registers and sets cfg_pending in every state. A later cfg_wr overwrites the shadow (last write wins).
- FSM states:
  - OFF: rx_en=0. If cfg_pending, go to APPLY. Else if enable=1, go to RUN.
  - RUN: rx_en=1. If enable=0 or cfg_pending: go to APPLY when frame_active=0, otherwise go to WAIT.
  - WAIT: rx_en=1; guard counter runs. On rx_valid (byte handled normally) or when the guard reaches GUARD_CYCLES, go to APPLY.
  - APPLY: exactly one cycle with rx_en=0. If cfg_pending, active <= shadow and cfg_pending <= 0 (a cfg_wr in this same cycle wins and keeps cfg_pending=1). Next state is RUN if enable=1, else OFF.
- Active configuration outputs change only in the APPLY state. They never change while rx_en=1.
- FIFO push: on rx_valid in any state except OFF, push {rx_parity_ok==0, rx_data}.
  - Full with no pop in the same cycle: byte is dropped and overrun <= 1.
  - Full with a pop in the same cycle: push is accepted and count is unchanged.
- FIFO pop: on m_valid && m_ready. Output is registered with no fall-through: a push into an empty FIFO gives m_valid=1 one cycle later. m_data/m_perr hold stable while m_valid && !m_ready.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH.
- perr_count increments on each rx_valid with rx_parity_ok=0, whether the byte is accepted or dropped. It saturates at 255.
- Idle timer:
  - Runs only when cfg_timeout!=0 and fifo_count!=0.
  - Resets to 0 on any push or pop.
  - timeout_irq <= 1 when the timer equals cfg_timeout.
  - timeout_irq clears on err_clr or on any pop.
- err_clr clears overrun, perr_count and timeout_irq. If a setting event occurs in the same cycle, the event wins (overrun=1, perr_count=1, or timeout_irq=1).

Test Plan:
- Reset, enable=1, rx_valid bytes 0xA5 then 0x3C with parity_ok=1, m_ready=1 -> m_valid one cycle after each push; m_data 0xA5 then 0x3C; m_perr=0; fifo_count returns to 0.
- m_ready=0, push 9 bytes -> fifo_count=8, 9th byte dropped, overrun=1; a pop and push in the same cycle when full leaves fifo_count=8; err_clr -> overrun=0.
- cfg_wr baud 20 after an rx falling edge -> cfg_pending=1; baud_divisor stays 10 until rx_valid; then rx_en=0 for exactly 1 cycle, baud_divisor=20, cfg_pending=0, rx_en=1.
- rx_valid 0x55 with parity_ok=0 -> head has m_perr=1, perr_count=1; 300 such bytes -> perr_count=255; err_clr and a parity error in the same cycle -> perr_count=1.
- cfg_timeout=100, one unread byte -> timeout_irq=1 at 100 cycles after the push; a pop clears it; cfg_timeout=0 -> never sets.
- Falling edge on rx then enable=0 with no rx_valid -> stays in WAIT for GUARD_CYCLES, then APPLY, then OFF with rx_en=0; reset asserted mid-WAIT with 3 bytes queued -> all outputs take reset values asynchronously.
